bpred_btb: RTL and testbench
============================

BPRED_BTB -- requirements
Module: bpred_btb

Interface
REQ-001 Parameter ENTRIES, default 16, number of direct-mapped table entries; power of two, 2..256.
REQ-002 Parameter CTR_BITS, default 2, saturating direction-counter width; 1..4.
REQ-003 Parameter PC_W, default 32, width of word-addressed PCs and targets.
REQ-004 Ports: clock  in  1  master clock; rising edge is the only active edge.
REQ-005 Ports: reset  in  1  asynchronous, active-high reset.
REQ-006 Ports: lookup_pc  in  PC_W  fetch-stage PC to predict.
REQ-007 Ports: pred_hit  out  1  valid entry with matching tag exists for lookup_pc.
REQ-008 Ports: pred_taken  out  1  predicted taken.
REQ-009 Ports: pred_target  out  PC_W  predicted next PC.
REQ-010 Ports: upd_valid  in  1  execute-stage resolved-branch update strobe.
REQ-011 Ports: upd_pc, upd_target  in  PC_W each  resolved branch PC and actual taken target.
REQ-012 Ports: upd_taken  in  1  actual outcome.
REQ-013 Ports: upd_pred_taken  in  1, upd_pred_target  in  PC_W  prediction carried down the pipe with the branch.
REQ-014 Ports: flush_all  in  1  synchronous invalidate of every entry.
REQ-015 Ports: mispredict  out  1  combinational; high when upd_valid and the prediction was wrong.

Function
REQ-016 Index = PC[log2(ENTRIES)-1:0]; tag = PC[PC_W-1:log2(ENTRIES)].
REQ-017 Lookup is combinational from table state; zero-cycle latency.
REQ-018 pred_hit = entry valid AND tag match.
REQ-019 pred_taken = pred_hit AND counter MSB = 1.
REQ-020 pred_target = stored target when pred_taken, else lookup_pc+1 (modulo 2^PC_W).
REQ-021 mispredict = upd_valid AND (upd_pred_taken != upd_taken OR (upd_taken AND upd_pred_target != upd_target)).
REQ-022 Update on a hit: counter increments if taken, decrements if not, saturating at 0 and 2^CTR_BITS-1; target overwritten when taken.
REQ-023 Update on a miss with upd_taken=1: allocate/replace the entry; valid=1, tag, target written, counter = 2^(CTR_BITS-1) (weakly taken).
REQ-024 Update on a miss with upd_taken=0: no table change.
REQ-025 All table writes occur at the rising edge in which upd_valid is sampled high; a same-cycle lookup of that index returns pre-update contents.
REQ-026 flush_all and upd_valid together: flush wins; all entries invalid after the edge, update discarded.
REQ-027 Unused counter/target bits of invalid entries are don't-care but never drive outputs.

Reset
REQ-028 While reset is high: all valid bits 0, counters 2^(CTR_BITS-1)-1, targets 0; pred_hit=0, pred_taken=0, pred_target=lookup_pc+1.
REQ-029 Reset asserted mid-update aborts the update; no partial entry survives.

Configuration
REQ-030 Macro BPRED_STATS_EN defined: add outputs stat_updates and stat_mispredicts, 32 bits each, incrementing on upd_valid and on mispredict respectively, wrapping at 2^32, cleared by reset, not by flush_all.
REQ-031 BPRED_STATS_EN undefined: those ports and counters do not exist; all other behaviour identical.

Structure
REQ-032 Package bpred_pkg holds default parameter values, the counter reset/allocate constants, and the entry record typedef (valid, tag, target, counter).
REQ-033 One sub-module, sat_counter (parameter CTR_BITS; inc/dec in, next value out), instantiated once on the update path.

Verification
REQ-034 After reset, lookup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x41.
REQ-035 Update pc=0x13 taken target=0x80 (pred not taken) -> mispredict=1; next cycle lookup 0x13 -> hit, taken, target 0x80.
REQ-036 With CTR_BITS=2, four not-taken updates to 0x13 after allocation -> counter saturates at 0; pred_taken=0; a further not-taken update leaves counter 0; mispredict=0 when pred inputs agree.
REQ-037 ENTRIES=16: allocate 0x13 then 0x23 (same index, different tag) -> lookup 0x13 misses, 0x23 hits.
REQ-038 flush_all and a taken update to 0x05 in the same cycle -> all lookups miss next cycle.
REQ-039 BPRED_STATS_EN build: 10 updates, 3 mispredicted -> stat_updates=10, stat_mispredicts=3; reset mid-sequence -> both 0.

Source files
------------

// File: rtl/bpred_pkg.sv
// ============================================================================
// Module   : bpred_pkg
// Purpose  : Shared defaults, counter constants and the BTB entry record used
//            by bpred_btb and its saturating-counter sub-module.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bpred_pkg;

   // Default configuration of the predictor
   localparam int DEF_ENTRIES  = 16;
   localparam int DEF_CTR_BITS = 2;
   localparam int DEF_PC_W     = 32;

   // Entry fields are sized for the widest legal configuration.
   // Narrower builds store zero-extended values, so the upper bits are constant.
   localparam int MAX_PC_W     = 64;
   localparam int MAX_CTR_BITS = 4;

   typedef struct packed {
      logic                    valid;
      logic [MAX_PC_W-1:0]     tag;
      logic [MAX_PC_W-1:0]     target;
      logic [MAX_CTR_BITS-1:0] ctr;
   } btb_entry_t;

   // Reset value: weakly not-taken, 2^(bits-1)-1
   function automatic logic [MAX_CTR_BITS-1:0] ctr_reset_val(input int bits);
      ctr_reset_val = MAX_CTR_BITS'((1 << (bits - 1)) - 1);
   endfunction

   // Allocate value: weakly taken, 2^(bits-1)
   function automatic logic [MAX_CTR_BITS-1:0] ctr_alloc_val(input int bits);
      ctr_alloc_val = MAX_CTR_BITS'(1 << (bits - 1));
   endfunction

endpackage

`default_nettype wire

// File: rtl/bpred_btb_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Combinational next-value logic for a saturating up/down counter.
//            Holds at 0 and at 2^CTR_BITS-1; holds when inc and dec agree.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter
   import bpred_pkg::*;
#(
   parameter int CTR_BITS = DEF_CTR_BITS
) (
   input  logic [CTR_BITS-1:0] value,
   input  logic                inc,
   input  logic                dec,
   output logic [CTR_BITS-1:0] next_value
);

   localparam logic [CTR_BITS-1:0] MAX_VAL = '1;

   // Step one towards the requested direction unless already at the rail
   always_comb begin
      next_value = value;
      if (inc && !dec && (value != MAX_VAL)) begin
         next_value = value + 1'b1;
      end else if (dec && !inc && (value != '0)) begin
         next_value = value - 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bpred_btb.sv
// ============================================================================
// Module   : bpred_btb
// Purpose  : Direct-mapped branch target buffer with per-entry saturating
//            direction counters. Lookup is combinational; updates and flush
//            take effect on the rising clock edge.
// Config   : define BPRED_STATS_EN to add stat_updates / stat_mispredicts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpred_btb
   import bpred_pkg::*;
#(
   parameter int ENTRIES  = DEF_ENTRIES,
   parameter int CTR_BITS = DEF_CTR_BITS,
   parameter int PC_W     = DEF_PC_W
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [PC_W-1:0] lookup_pc,
   output logic            pred_hit,
   output logic            pred_taken,
   output logic [PC_W-1:0] pred_target,
   input  logic            upd_valid,
   input  logic [PC_W-1:0] upd_pc,
   input  logic [PC_W-1:0] upd_target,
   input  logic            upd_taken,
   input  logic            upd_pred_taken,
   input  logic [PC_W-1:0] upd_pred_target,
   input  logic            flush_all,
   output logic            mispredict
`ifdef BPRED_STATS_EN
   ,
   output logic [31:0]     stat_updates,
   output logic [31:0]     stat_mispredicts
`endif
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W;

   localparam logic [MAX_CTR_BITS-1:0] CTR_RST   = ctr_reset_val(CTR_BITS);
   localparam logic [MAX_CTR_BITS-1:0] CTR_ALLOC = ctr_alloc_val(CTR_BITS);

   btb_entry_t btb_q [ENTRIES];

   logic [IDX_W-1:0]    look_idx;
   logic [TAG_W-1:0]    look_tag;
   logic [IDX_W-1:0]    upd_idx;
   logic [TAG_W-1:0]    upd_tag;
   logic                upd_hit;
   logic [CTR_BITS-1:0] ctr_cur;
   logic [CTR_BITS-1:0] ctr_next;

   assign look_idx = lookup_pc[IDX_W-1:0];
   assign look_tag = lookup_pc[PC_W-1:IDX_W];
   assign upd_idx  = upd_pc[IDX_W-1:0];
   assign upd_tag  = upd_pc[PC_W-1:IDX_W];

   // Lookup path reads the table as it stands; writes land only at the edge
   assign pred_hit    = btb_q[look_idx].valid
                        && (btb_q[look_idx].tag == MAX_PC_W'(look_tag));
   assign pred_taken  = pred_hit && btb_q[look_idx].ctr[CTR_BITS-1];
   assign pred_target = pred_taken ? btb_q[look_idx].target[PC_W-1:0]
                                   : lookup_pc + 1'b1;

   assign mispredict = upd_valid
                       && ((upd_pred_taken != upd_taken)
                           || (upd_taken && (upd_pred_target != upd_target)));

   assign upd_hit = btb_q[upd_idx].valid
                    && (btb_q[upd_idx].tag == MAX_PC_W'(upd_tag));
   assign ctr_cur = btb_q[upd_idx].ctr[CTR_BITS-1:0];

   sat_counter #(
      .CTR_BITS   (CTR_BITS)
   ) u_ctr (
      .value      (ctr_cur),
      .inc        (upd_taken),
      .dec        (!upd_taken),
      .next_value (ctr_next)
   );

   // Table state: flush beats update; a miss allocates only on a taken branch
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_q[i].valid  <= 1'b0;
            btb_q[i].tag    <= '0;
            btb_q[i].target <= '0;
            btb_q[i].ctr    <= CTR_RST;
         end
      end else if (flush_all) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_q[i].valid <= 1'b0;
         end
      end else if (upd_valid) begin
         if (upd_hit) begin
            btb_q[upd_idx].ctr <= MAX_CTR_BITS'(ctr_next);
            if (upd_taken) begin
               btb_q[upd_idx].target <= MAX_PC_W'(upd_target);
            end
         end else if (upd_taken) begin
            btb_q[upd_idx].valid  <= 1'b1;
            btb_q[upd_idx].tag    <= MAX_PC_W'(upd_tag);
            btb_q[upd_idx].target <= MAX_PC_W'(upd_target);
            btb_q[upd_idx].ctr    <= CTR_ALLOC;
         end
      end
   end

`ifdef BPRED_STATS_EN
   // Event counters survive flush_all and wrap naturally at 2^32
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_updates     <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (upd_valid) begin
            stat_updates <= stat_updates + 32'd1;
         end
         if (mispredict) begin
            stat_mispredicts <= stat_mispredicts + 32'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bpred_btb.sv
// ============================================================================
// Module   : tb_bpred_btb
// Purpose  : Self-checking bench for bpred_btb (default parameters).
//            Define BPRED_STATS_EN to exercise the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bpred_btb;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] lookup_pc;
   logic        pred_hit;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        flush_all;
   logic        mispredict;
`ifdef BPRED_STATS_EN
   logic [31:0] stat_updates;
   logic [31:0] stat_mispredicts;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   bpred_btb dut (
      .clock           (clock),
      .reset           (reset),
      .lookup_pc       (lookup_pc),
      .pred_hit        (pred_hit),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_target      (upd_target),
      .upd_taken       (upd_taken),
      .upd_pred_taken  (upd_pred_taken),
      .upd_pred_target (upd_pred_target),
      .flush_all       (flush_all),
      .mispredict      (mispredict)
`ifdef BPRED_STATS_EN
      ,
      .stat_updates    (stat_updates),
      .stat_mispredicts(stat_mispredicts)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: 16 slots keyed by pc mod 16 ----------
   bit          m_valid [16];
   logic [27:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];
   logic [31:0] m_upd;
   logic [31:0] m_mp;

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[pc % 16] && (m_tag[pc % 16] == 28'(pc / 16));
   endfunction

   function automatic bit m_mispred();
      if (!upd_valid) return 1'b0;
      if (upd_pred_taken != upd_taken) return 1'b1;
      return upd_taken && (upd_pred_target != upd_target);
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            m_valid[i] <= 1'b0;
            m_ctr[i]   <= 1;
            m_tgt[i]   <= '0;
         end
         m_upd <= '0;
         m_mp  <= '0;
      end else begin
         if (upd_valid) m_upd <= m_upd + 1;
         if (m_mispred()) m_mp <= m_mp + 1;
         if (flush_all) begin
            for (int i = 0; i < 16; i++) m_valid[i] <= 1'b0;
         end else if (upd_valid) begin
            if (m_hit(upd_pc)) begin
               if (upd_taken) begin
                  m_ctr[upd_pc % 16] <= (m_ctr[upd_pc % 16] == 3) ? 3 : m_ctr[upd_pc % 16] + 1;
                  m_tgt[upd_pc % 16] <= upd_target;
               end else begin
                  m_ctr[upd_pc % 16] <= (m_ctr[upd_pc % 16] == 0) ? 0 : m_ctr[upd_pc % 16] - 1;
               end
            end else if (upd_taken) begin
               m_valid[upd_pc % 16] <= 1'b1;
               m_tag[upd_pc % 16]   <= 28'(upd_pc / 16);
               m_tgt[upd_pc % 16]   <= upd_target;
               m_ctr[upd_pc % 16]   <= 2;
            end
         end
      end
   end

   // Compare every cycle, midway between active edges
   always @(negedge clock) begin
      automatic bit          e_hit   = m_hit(lookup_pc);
      automatic bit          e_taken = e_hit && (m_ctr[lookup_pc % 16] >= 2);
      automatic logic [31:0] e_tgt   = e_taken ? m_tgt[lookup_pc % 16] : lookup_pc + 32'd1;
      check("model_hit",    64'(pred_hit),    64'(e_hit));
      check("model_taken",  64'(pred_taken),  64'(e_taken));
      check("model_target", 64'(pred_target), 64'(e_tgt));
      check("model_mispredict", 64'(mispredict), 64'(m_mispred()));
`ifdef BPRED_STATS_EN
      check("model_stat_upd", 64'(stat_updates),     64'(m_upd));
      check("model_stat_mp",  64'(stat_mispredicts), 64'(m_mp));
`endif
   end

   // ---------------- stimulus helpers ----------------------------------------
   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                      input logic ptk, input logic [31:0] ptgt);
      upd_valid       = 1'b1;
      upd_pc          = pc;
      upd_target      = tgt;
      upd_taken       = tk;
      upd_pred_taken  = ptk;
      upd_pred_target = ptgt;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
      upd_valid = 1'b0;
      flush_all = 1'b0;
   endtask

   task automatic look(input logic [31:0] pc, input logic eh, input logic et,
                       input logic [31:0] etgt, input string name);
      lookup_pc = pc;
      @(negedge clock);
      check({name, "_hit"},    64'(pred_hit),    64'(eh));
      check({name, "_taken"},  64'(pred_taken),  64'(et));
      check({name, "_target"}, 64'(pred_target), 64'(etgt));
      next_cycle();
   endtask

   initial begin
      reset = 1'b1; lookup_pc = 32'h40; flush_all = 1'b0;
      upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
      upd_pred_taken = 1'b0; upd_pred_target = '0;
      @(negedge clock);
      check("in_reset_hit",    64'(pred_hit),    64'h0);
      check("in_reset_target", 64'(pred_target), 64'h41);
      next_cycle();
      reset = 1'b0;

      look(32'h40, 1'b0, 1'b0, 32'h41, "post_reset");

      // allocate 0x13; same-cycle lookup still sees the old (empty) slot
      lookup_pc = 32'h13;
      upd(32'h13, 32'h80, 1'b1, 1'b0, 32'h0);
      @(negedge clock);
      check("alloc_mispredict", 64'(mispredict), 64'h1);
      check("alloc_same_cycle_hit", 64'(pred_hit), 64'h0);
      next_cycle();
      look(32'h13, 1'b1, 1'b1, 32'h80, "after_alloc");

      // five not-taken updates: 2 -> 1 -> 0 -> 0 -> 0 -> 0
      for (int i = 0; i < 5; i++) begin
         upd(32'h13, 32'h14, 1'b0, 1'b0, 32'h14);
         @(negedge clock);
         check("nt_mispredict", 64'(mispredict), 64'h0);
         next_cycle();
      end
      look(32'h13, 1'b1, 1'b0, 32'h14, "sat_low");

      // one taken: counter 0->1, target rewritten but not yet predicted
      upd(32'h13, 32'h90, 1'b1, 1'b0, 32'h0);
      next_cycle();
      look(32'h13, 1'b1, 1'b0, 32'h14, "ctr_one");
      upd(32'h13, 32'h90, 1'b1, 1'b0, 32'h0);
      next_cycle();
      look(32'h13, 1'b1, 1'b1, 32'h90, "ctr_two");

      // drive to the top rail, then one not-taken must stay taken
      for (int i = 0; i < 3; i++) begin
         upd(32'h13, 32'h90, 1'b1, 1'b1, 32'h90);
         next_cycle();
      end
      upd(32'h13, 32'h90, 1'b0, 1'b1, 32'h90);
      next_cycle();
      look(32'h13, 1'b1, 1'b1, 32'h90, "sat_high");

      // same index, different tag replaces the entry
      upd(32'h23, 32'h100, 1'b1, 1'b0, 32'h0);
      next_cycle();
      look(32'h13, 1'b0, 1'b0, 32'h14,  "evicted");
      look(32'h23, 1'b1, 1'b1, 32'h100, "replacer");

      // mispredict corner cases
      upd(32'h23, 32'h100, 1'b1, 1'b1, 32'h104);
      @(negedge clock);
      check("tgt_mismatch_mp", 64'(mispredict), 64'h1);
      next_cycle();
      upd(32'h23, 32'h55, 1'b0, 1'b0, 32'h77);
      @(negedge clock);
      check("nt_tgt_ignored_mp", 64'(mispredict), 64'h0);
      next_cycle();
      upd(32'h23, 32'h55, 1'b1, 1'b0, 32'h77);
      upd_valid = 1'b0;
      @(negedge clock);
      check("no_valid_mp", 64'(mispredict), 64'h0);
      next_cycle();

      // flush wins over a simultaneous allocate
      upd(32'h05, 32'h60, 1'b1, 1'b0, 32'h0);
      flush_all = 1'b1;
      next_cycle();
      look(32'h05, 1'b0, 1'b0, 32'h06, "flush_new");
      look(32'h23, 1'b0, 1'b0, 32'h24, "flush_old");

      // PC wrap and a top-of-range tag
      look(32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, "pc_wrap");
      upd(32'hFFFF_FFF3, 32'h7, 1'b1, 1'b0, 32'h0);
      next_cycle();
      look(32'hFFFF_FFF3, 1'b1, 1'b1, 32'h7, "high_tag");
      look(32'h0000_0003, 1'b0, 1'b0, 32'h4, "low_alias");

      // reset arriving during an update aborts it
      lookup_pc = 32'h0A;
      upd(32'h0A, 32'h33, 1'b1, 1'b0, 32'h0);
      @(negedge clock);
      #1 reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      look(32'h0A, 1'b0, 1'b0, 32'h0B, "reset_abort");
      look(32'hFFFF_FFF3, 1'b0, 1'b0, 32'hFFFF_FFF4, "reset_clears");

`ifdef BPRED_STATS_EN
      @(negedge clock);
      #1 reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         upd(32'h30 + i, 32'h200 + i, 1'b1, (i >= 3), 32'h200 + i);
         next_cycle();
      end
      @(negedge clock);
      check("stat_updates_10", 64'(stat_updates),     64'd10);
      check("stat_mp_3",       64'(stat_mispredicts), 64'd3);
      next_cycle();
      flush_all = 1'b1;
      next_cycle();
      @(negedge clock);
      check("stat_keep_flush", 64'(stat_updates), 64'd10);
      #1 reset = 1'b1;
      @(posedge clock);
      #1;
      check("stat_upd_reset", 64'(stat_updates),     64'd0);
      check("stat_mp_reset",  64'(stat_mispredicts), 64'd0);
      reset = 1'b0;
      next_cycle();
`endif

      repeat (2) @(posedge clock);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
